// File: rtl/sixteen_to_four_encoder_if.sv
// Request/beat bundle for the 16-to-4 encoder: capture side (a/en/in_valid/in_ready)
// and emit side (out/out_valid/out_ready/out_last/out_zero).
interface sixteen_to_four_encoder_if;
    logic [15:0] a;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_zero;

    // The encoder itself sits on the slave side.
    modport slave (
        input  a,
        input  en,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready,
        output out_last,
        output out_zero
    );

    modport master (
        output a,
        output en,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  out_zero
    );
endinterface

// File: rtl/sixteen_to_four_encoder.sv
// Captures a multi-hot 16-bit request vector and emits the index of each set bit
// as one beat per handshake, highest or lowest index first.
module sixteen_to_four_encoder #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    sixteen_to_four_encoder_if.slave    bus
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] pending;
    logic        zero_flag;
    logic [3:0]  sel_idx;
    logic        single_bit;
    logic        last_beat;
    logic        capture;
    logic        accept;

    // The later match in the scan wins, so scan direction picks service order.
    function automatic logic [3:0] pick_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) idx = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign sel_idx    = pick_index(pending);
    assign single_bit = (pending != 16'd0) && ((pending & (pending - 16'd1)) == 16'd0);
    assign last_beat  = zero_flag || single_bit;
    assign capture    = (state == IDLE) && bus.in_valid && bus.en;
    assign accept     = (state == EMIT) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (capture) next_state = EMIT;
            EMIT:    if (accept && last_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A zero vector leaves pending empty; the zero flag alone carries its single beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 16'd0;
            zero_flag <= 1'b0;
        end else if (capture) begin
            pending   <= bus.a;
            zero_flag <= (bus.a == 16'd0);
        end else if (accept) begin
            if (last_beat) begin
                pending   <= 16'd0;
                zero_flag <= 1'b0;
            end else begin
                pending   <= pending & ~(16'd1 << sel_idx);
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = 1'b0;
        bus.out       = 4'd0;
        bus.out_last  = 1'b0;
        bus.out_zero  = 1'b0;
        if (state == EMIT) begin
            bus.out_valid = 1'b1;
            bus.out       = sel_idx;
            bus.out_last  = last_beat;
            bus.out_zero  = zero_flag;
        end
    end

endmodule

// File: tb/tb_sixteen_to_four_encoder.sv
// Drives a high-first and a low-first encoder in lockstep and compares every beat
// against the ordered list of set-bit indices of the captured vector.
module tb_sixteen_to_four_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sixteen_to_four_encoder_if bus_h ();
    sixteen_to_four_encoder_if bus_l ();

    sixteen_to_four_encoder #(.HIGH_FIRST(1'b1)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    sixteen_to_four_encoder #(.HIGH_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [15:0] a, input logic en,
                                 input logic in_valid, input logic out_ready);
        bus_h.a = a;  bus_h.en = en;  bus_h.in_valid = in_valid;  bus_h.out_ready = out_ready;
        bus_l.a = a;  bus_l.en = en;  bus_l.in_valid = in_valid;  bus_l.out_ready = out_ready;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready_h"}, 16'(bus_h.in_ready), 16'd1);
        checkOutput({tag, "_in_ready_l"}, 16'(bus_l.in_ready), 16'd1);
        checkOutput({tag, "_valid_h"},    16'(bus_h.out_valid), 16'd0);
        checkOutput({tag, "_valid_l"},    16'(bus_l.out_valid), 16'd0);
        checkOutput({tag, "_out_h"},      16'(bus_h.out), 16'd0);
        checkOutput({tag, "_out_l"},      16'(bus_l.out), 16'd0);
        checkOutput({tag, "_last_h"},     16'(bus_h.out_last), 16'd0);
        checkOutput({tag, "_zero_l"},     16'(bus_l.out_zero), 16'd0);
    endtask

    task automatic checkBeat(input int idx_h, input int idx_l, input bit last, input bit zero);
        checkOutput("beat_valid_h", 16'(bus_h.out_valid), 16'd1);
        checkOutput("beat_valid_l", 16'(bus_l.out_valid), 16'd1);
        checkOutput("beat_out_h",   16'(bus_h.out), 16'(idx_h));
        checkOutput("beat_out_l",   16'(bus_l.out), 16'(idx_l));
        checkOutput("beat_last_h",  16'(bus_h.out_last), 16'(last));
        checkOutput("beat_last_l",  16'(bus_l.out_last), 16'(last));
        checkOutput("beat_zero_h",  16'(bus_h.out_zero), 16'(zero));
        checkOutput("beat_zero_l",  16'(bus_l.out_zero), 16'(zero));
        checkOutput("beat_in_ready_h", 16'(bus_h.in_ready), 16'd0);
    endtask

    // Capture one vector, then walk its expected beats with optional backpressure.
    task automatic runVector(input logic [15:0] v, input int stall_first, input bit rand_ready);
        int   exp_h[$];
        int   exp_l[$];
        int   n;
        int   k;
        int   cyc;
        int   stalls;
        logic ready;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                exp_l.push_back(i);
                exp_h.push_front(i);
            end
        end
        if (v == 16'd0) begin
            exp_l.push_back(0);
            exp_h.push_back(0);
        end
        n = exp_h.size();
        @(negedge clk);
        checkOutput("capture_in_ready_h", 16'(bus_h.in_ready), 16'd1);
        checkOutput("capture_in_ready_l", 16'(bus_l.in_ready), 16'd1);
        applyStimulus(v, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        k = 0;
        cyc = 0;
        stalls = 0;
        while (k < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            checkBeat(exp_h[k], exp_l[k], (k == n - 1), (v == 16'd0));
            if (stalls < stall_first) begin
                ready = 1'b0;
                stalls++;
            end else begin
                ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ready);
            if (ready) k++;
        end
        if (k < n) checkOutput("beat_timeout", 16'(k), 16'(n));
        @(negedge clk);
        checkIdle("after_last");
        applyStimulus(16'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput("reset_in_ready_h", 16'(bus_h.in_ready), 16'd0);
        checkOutput("reset_valid_h",    16'(bus_h.out_valid), 16'd0);
        checkOutput("reset_valid_l",    16'(bus_l.out_valid), 16'd0);
        checkOutput("reset_out_h",      16'(bus_h.out), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle("reset_release");

        $display("[TB] directed vectors");
        runVector(16'h0100, 0, 1'b0);
        runVector(16'h8421, 0, 1'b0);
        runVector(16'h0003, 5, 1'b0);
        runVector(16'h0000, 0, 1'b0);

        $display("[TB] enable gating");
        @(negedge clk);
        applyStimulus(16'h1234, 1'b0, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkIdle("en_low");
        end
        applyStimulus(16'h5678, 1'b1, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checkIdle("valid_low");
        end

        $display("[TB] reset during emit");
        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBeat(15 - i, i, 1'b0, 1'b0);
            applyStimulus(16'($urandom), 1'b1, 1'b1, 1'b1);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_valid_h",    16'(bus_h.out_valid), 16'd0);
        checkOutput("rst_valid_l",    16'(bus_l.out_valid), 16'd0);
        checkOutput("rst_out_h",      16'(bus_h.out), 16'd0);
        checkOutput("rst_in_ready_l", 16'(bus_l.in_ready), 16'd0);
        applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle("rst_mid_release");
        repeat (3) begin
            @(negedge clk);
            checkIdle("rst_no_beats");
        end

        $display("[TB] single-bit sweep");
        for (int i = 0; i < 16; i++) runVector(16'd1 << i, 0, 1'b0);

        $display("[TB] random vectors");
        for (int i = 0; i < 40; i++) runVector(16'($urandom), int'($urandom_range(0, 3)), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
